// File: rtl/mips32_multi_cycle_pkg.sv
// mips32_multi_cycle_pkg: opcodes, FSM states and ALU helpers shared by the multi-cycle core
package mips32_multi_cycle_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL} alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20, FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) return fn inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU};
    return op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
  endfunction
  function automatic alu_op_t alu_decode(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op != OP_RTYPE ? ALU_ADD :
      fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
      fn == FN_SLT ? ALU_SLT : fn == FN_SLTU ? ALU_SLTU : fn == FN_SLL ? ALU_SLL :
      fn == FN_SRL ? ALU_SRL : ALU_ADD;
  endfunction
  function automatic logic [31:0] alu(input alu_op_t f, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] sh);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_SLL:  return b << sh;
      default:  return b >> sh;
    endcase
  endfunction
endpackage

// File: rtl/mips32_multi_cycle_if.sv
// mips32_multi_cycle_if: shared instruction/data memory port with a req/ack handshake
interface mips32_multi_cycle_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mips32_multi_cycle_regfile.sv
// mips32_multi_cycle_regfile: 32x32 registers, two async reads, one sync write, r0 reads as zero
module mips32_multi_cycle_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] da,
  output logic [31:0] db
);
  logic [31:0] regs [32];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign da = ra == 5'd0 ? '0 : regs[ra];
  assign db = rb == 5'd0 ? '0 : regs[rb];
endmodule

// File: rtl/mips32_multi_cycle.sv
// mips32_multi_cycle: multi-cycle MIPS32 core; fetch and data share one req/ack memory port
module mips32_multi_cycle
  import mips32_multi_cycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mips32_multi_cycle_if.master mem,
  output logic [31:0]          pc,
  output logic                 instr_done,
  output logic                 trap
);
  state_t state, state_nx;
  logic [31:0] ir, npc, a, b, alu_out, mdr, rf_a, rf_b, pc_nx, wd, addr, sext, opb;
  logic [5:0] op;
  logic [4:0] wa;
  logic we, pc_ld, req, go, branch, jump, taken;
  assign op     = ir[31:26];
  assign sext   = {{16{ir[15]}}, ir[15:0]};
  assign opb    = op == OP_RTYPE ? b : (op == OP_ANDI || op == OP_ORI) ? {16'h0, ir[15:0]} : sext;
  assign jump   = op == OP_J || op == OP_JAL;
  assign branch = jump || op == OP_BEQ || op == OP_BNE;
  assign taken  = op == OP_BEQ ? a == b : a != b;
  assign trap   = state == S_TRAP;
  mips32_multi_cycle_regfile rf (
    .clk(clk), .reset(reset), .ra(ir[25:21]), .rb(ir[20:16]),
    .we(we), .wa(wa), .wd(wd), .da(rf_a), .db(rf_b)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      {ir, npc, a, b, alu_out, mdr} <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && mem.mem_ack) begin
        ir <= mem.mem_rdata;
        npc <= pc + 32'd4;
      end
      if (state == S_DECODE) {a, b} <= {rf_a, rf_b};
      if (state == S_EXEC) alu_out <= alu(alu_decode(op, ir[5:0]), a, opb, ir[10:6]);
      if (state == S_MEM && mem.mem_ack) mdr <= mem.mem_rdata;
      if (pc_ld) pc <= pc_nx;
    end
  always_comb begin
    state_nx = state;
    pc_ld = 1'b0;
    pc_nx = npc;
    we = 1'b0;
    wa = ir[20:16];
    wd = alu_out;
    instr_done = 1'b0;
    req = 1'b0;
    addr = alu_out;
    case (state)
      S_FETCH: begin
        req = 1'b1;
        addr = pc;
        state_nx = mem.mem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_nx = legal(op, ir[5:0]) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        state_nx = (op == OP_LW || op == OP_SW) ? S_MEM : branch ? S_FETCH : S_WB;
        pc_ld = branch;
        instr_done = branch;
        pc_nx = jump ? {npc[31:28], ir[25:0], 2'b00} : taken ? npc + {sext[29:0], 2'b00} : npc;
        we = op == OP_JAL;
        wa = 5'd31;
        wd = npc;
      end
      S_MEM: begin
        req = 1'b1;
        state_nx = !mem.mem_ack ? S_MEM : op == OP_SW ? S_FETCH : S_WB;
        pc_ld = mem.mem_ack && op == OP_SW;
        instr_done = pc_ld;
      end
      S_WB: begin
        we = 1'b1;
        wa = op == OP_RTYPE ? ir[15:11] : ir[20:16];
        wd = op == OP_LW ? mdr : alu_out;
        pc_ld = 1'b1;
        instr_done = 1'b1;
        state_nx = S_FETCH;
      end
      default: ;
    endcase
  end
  // Reset gates the request combinationally so a pending transaction is dropped at once
  assign go            = req && !reset;
  assign mem.mem_req   = go;
  assign mem.mem_we    = go && state == S_MEM && op == OP_SW;
  assign mem.mem_addr  = go ? ADDR_W'(addr & ~32'h3) : '0;
  assign mem.mem_wdata = mem.mem_we ? b : '0;
endmodule
